pot_scan_core: RTL and testbench

POT_SCAN_CORE -- requirements
Module: pot_scan_core

---
 rtl/pot_scan_core.sv | 65 ++++++
 tb/tb_pot_scan_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_core.sv
// pot_scan_core: pot capacitor discharge/scan timer with per-channel result latches.
// Define POT_SCAN_IRQ_EN to add the irq/irqAck completion interrupt.
module pot_scan_core #(
  parameter int NCH    = 8,
  parameter int CW     = 8,
  parameter int MAXCNT = 228
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              tick,
  input  logic              potGo,
  input  logic              fastScan,
  input  logic [NCH-1:0]    p,
`ifdef POT_SCAN_IRQ_EN
  input  logic              irqAck,
  output logic              irq,
`endif
  output logic              dump,
  output logic [NCH*CW-1:0] potVal,
  output logic [NCH-1:0]    allPot,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, DUMP = 2'd1, SCAN = 2'd2;
  if (MAXCNT < 1 || MAXCNT > (1 << CW) - 1 || NCH < 1 || NCH > 16 || CW < 4 || CW > 12) begin : g_bad_param
    $error("pot_scan_core: parameter out of range");
  end
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          dump_cnt;
  logic          step, scan, term;
  assign step = fastScan | tick;
  assign scan = state == SCAN && !potGo;
  assign term = scan && step && cnt == CW'(MAXCNT - 1);
  assign dump = state != SCAN;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state    <= IDLE;
      cnt      <= '0;
      dump_cnt <= 1'b0;
      potVal   <= '0;
      allPot   <= '0;
    end else if (potGo) begin
      state    <= DUMP;
      cnt      <= '0;
      dump_cnt <= 1'b0;
      allPot   <= '1;
    end else if (state == DUMP) begin
      dump_cnt <= 1'b1;
      if (dump_cnt) state <= SCAN;
    end else if (state == SCAN) begin
      // terminal step forces every still-counting channel to MAXCNT
      for (int i = 0; i < NCH; i++)
        if (allPot[i] && (p[i] || term)) potVal[i*CW +: CW] <= term ? CW'(MAXCNT) : cnt;
      allPot <= term ? '0 : allPot & ~p;
      if (step) cnt <= cnt + 1'b1;
      if (term) state <= IDLE;
    end
`ifdef POT_SCAN_IRQ_EN
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) irq <= 1'b0;
    else if (potGo || irqAck) irq <= 1'b0;
    else if (term) irq <= 1'b1;
`endif
endmodule

// File: tb/tb_pot_scan_core.sv
// tb_pot_scan_core: randomized scans against a per-channel threshold model.
module tb_pot_scan_core;
  localparam int NCH = 8, CW = 8, MAXCNT = 228;
  localparam logic [NCH-1:0] ONES = '1;
  logic clk = 0, nRst = 0, tick = 0, potGo = 0, fastScan = 0;
  logic [NCH-1:0] p = '0;
  logic dump, busy;
  logic [NCH*CW-1:0] potVal;
  logic [NCH-1:0] allPot;
`ifdef POT_SCAN_IRQ_EN
  logic irqAck = 0, irq;
  logic irq_exp = 0;
`endif
  int n_chk = 0, n_err = 0;
  int exp_val[NCH];
  int thr[NCH];
  logic [NCH-1:0] alive = '0;
  int k = 0, cyc = 0;

  pot_scan_core #(.NCH(NCH), .CW(CW), .MAXCNT(MAXCNT)) dut (
    .clk(clk), .nRst(nRst), .tick(tick), .potGo(potGo), .fastScan(fastScan), .p(p),
`ifdef POT_SCAN_IRQ_EN
    .irqAck(irqAck), .irq(irq),
`endif
    .dump(dump), .potVal(potVal), .allPot(allPot), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*CW-1:0] exp_vec();
    logic [NCH*CW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*CW +: CW] = CW'(exp_val[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_thr(input int hi);
    for (int i = 0; i < NCH; i++) thr[i] = $urandom_range(0, hi);
  endtask

  task automatic start_scan(input logic [NCH-1:0] pv);
    potGo = 1; p = pv; fastScan = 1; tick = 1'($urandom % 2);
`ifdef POT_SCAN_IRQ_EN
    irqAck = 1'($urandom % 2);
`endif
    step_clk();
    potGo = 0;
`ifdef POT_SCAN_IRQ_EN
    irqAck = 0; irq_exp = 0;
    check("irq_go", irq, irq_exp);
`endif
    check("go_allpot", allPot, ONES);
    check("go_dump", dump, 1);
    check("go_busy", busy, 1);
    check("go_keep", potVal, exp_vec());
    p = NCH'($urandom); fastScan = 1'($urandom % 2); tick = 1;
    step_clk();
    check("dump1", dump, 1);
    check("dump1_allpot", allPot, ONES);
    p = NCH'($urandom);
    step_clk();
    check("dump_end", dump, 0);
    check("dump_end_busy", busy, 1);
    check("dump_end_allpot", allPot, ONES);
    alive = ONES; k = 0; cyc = 0;
  endtask

  // mode: 0 = tick every 4 clk, 1 = fastScan, 2 = random mix
  task automatic run_scan(input int mode, input int abort_at, input bit ack_term);
    bit aborted = 0;
    bit s, termc;
    int budget = 4000;
    start_scan(NCH'($urandom));
    while (1) begin
      budget--;
      if (budget == 0) begin
        check("timeout", 0, 1);
        return;
      end
      if (!aborted && k == abort_at) begin
        aborted = 1;
        start_scan(ONES);
        continue;
      end
      fastScan = mode == 1 ? 1'b1 : mode == 0 ? 1'b0 : 1'($urandom % 2);
      tick = mode == 0 ? (cyc % 4 == 3) : 1'($urandom % 2);
      cyc++;
      for (int i = 0; i < NCH; i++) p[i] = alive[i] ? (k >= thr[i]) : 1'($urandom % 2);
      s = fastScan | tick;
      termc = s && k == MAXCNT - 1;
`ifdef POT_SCAN_IRQ_EN
      irqAck = (termc && ack_term) ? 1'b1 : ($urandom % 8 == 0);
`endif
      for (int i = 0; i < NCH; i++)
        if (alive[i] && (p[i] || termc)) begin
          exp_val[i] = termc ? MAXCNT : k;
          alive[i] = 0;
        end
      step_clk();
      if (s) k++;
`ifdef POT_SCAN_IRQ_EN
      irq_exp = irqAck ? 1'b0 : termc ? 1'b1 : irq_exp;
      irqAck = 0;
      check("irq", irq, irq_exp);
`endif
      check("allpot", allPot, alive);
      if (termc) begin
        check("end_busy", busy, 0);
        check("end_dump", dump, 1);
        check("end_potval", potVal, exp_vec());
        return;
      end
      check("scan_dump", dump, 0);
      check("scan_busy", busy, 1);
    end
  endtask

  task automatic idle_hold(input int n);
    repeat (n) begin
      p = NCH'($urandom); fastScan = 1'($urandom % 2); tick = 1'($urandom % 2);
`ifdef POT_SCAN_IRQ_EN
      irqAck = ($urandom % 4 == 0);
`endif
      step_clk();
`ifdef POT_SCAN_IRQ_EN
      irq_exp = irqAck ? 1'b0 : irq_exp;
      irqAck = 0;
      check("idle_irq", irq, irq_exp);
`endif
      check("idle_dump", dump, 1);
      check("idle_busy", busy, 0);
      check("idle_allpot", allPot, alive);
      check("idle_potval", potVal, exp_vec());
    end
  endtask

  initial begin
    p = NCH'($urandom);
    #3;
    check("rst_dump", dump, 1);
    check("rst_busy", busy, 0);
    check("rst_potval", potVal, 0);
    check("rst_allpot", allPot, 0);
    #9 nRst = 1;
    step_clk();
    idle_hold(3);
    rand_thr(MAXCNT + 10); thr[3] = 50; thr[5] = MAXCNT - 1;
    run_scan(1, -1, 0);
    check("ch3_50", potVal[3*CW +: CW], 50);
    check("ch5_max", potVal[5*CW +: CW], MAXCNT);
`ifdef POT_SCAN_IRQ_EN
    check("irq_set", irq, irq_exp);
    irqAck = 1;
    step_clk();
    irqAck = 0;
    check("irq_ack", irq, 0);
    irq_exp = 0;
`endif
    idle_hold(4);
    rand_thr(MAXCNT + 10); thr[0] = 10;
    run_scan(0, -1, 0);
    check("ch0_10", potVal[0*CW +: CW], 10);
    idle_hold(2);
    rand_thr(40);
    run_scan(2, -1, 0);
    rand_thr(MAXCNT + 10);
    run_scan(1, 100, 0);
    rand_thr(MAXCNT + 10);
    run_scan(1, MAXCNT - 1, 1);
    idle_hold(2);
    repeat (4) begin
      rand_thr(MAXCNT + 20);
      run_scan(2, $urandom_range(0, MAXCNT + 50), 1'($urandom % 2));
      idle_hold(2);
    end
    rand_thr(MAXCNT);
    start_scan(NCH'($urandom));
    fastScan = 1; p = NCH'($urandom);
    repeat (30) step_clk();
    #2 nRst = 0;
    #1;
    check("mid_rst_dump", dump, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_potval", potVal, 0);
    check("mid_rst_allpot", allPot, 0);
`ifdef POT_SCAN_IRQ_EN
    check("mid_rst_irq", irq, 0);
    irq_exp = 0;
`endif
    for (int i = 0; i < NCH; i++) exp_val[i] = 0;
    alive = '0;
    step_clk();
    nRst = 1;
    idle_hold(5);
    rand_thr(MAXCNT + 10);
    run_scan(2, -1, 0);
    idle_hold(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
